// File: rtl/chan_mux_sync.sv
`default_nettype none
// ============================================================================
// Module      : chan_mux_sync
// Description : Registered N-channel, WIDTH-bit data selector. Channel
//               changes are requested over a ready/valid handshake and are
//               followed by a BLANK_CYC-cycle blanking window during which
//               data_out_valid is low, so no mixed or mid-switch sample is
//               ever qualified downstream.
// Config      : CHAN_MUX_HOLD_EN - when defined, data_out holds the last
//               qualified sample during blanking; when undefined it is
//               forced to zero from the accept edge through blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module chan_mux_sync #(
  parameter int N_CH      = 4,
  parameter int WIDTH     = 8,
  parameter int BLANK_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH*WIDTH-1:0]     data_in,
  input  logic [$clog2(N_CH)-1:0]   sel_req,
  input  logic                      sel_valid,
  output logic                      sel_ready,
  output logic [$clog2(N_CH)-1:0]   sel_cur,
  output logic [WIDTH-1:0]          data_out,
  output logic                      data_out_valid,
  output logic                      sel_err
);

  localparam int SEL_W = $clog2(N_CH);
  localparam int CNT_W = $clog2(BLANK_CYC) + 1;

  localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [SEL_W:0]   c_N_CH     = (SEL_W + 1)'(N_CH);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SEL_W-1:0]   r_pend;
  logic [SEL_W-1:0]   w_pend_nxt;
  logic [SEL_W-1:0]   r_sel_cur;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [WIDTH-1:0]   r_data_out;
  logic [WIDTH-1:0]   w_data_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic               r_err;
  logic               w_err_nxt;
  logic               w_ready;

  logic [WIDTH-1:0]   w_ch [N_CH];
  logic [WIDTH-1:0]   w_sample;
  logic [WIDTH-1:0]   w_blank_data;
  logic               w_req_oor;

  // Unpack the flat input bus into one word per channel
  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign w_ch[k] = data_in[k*WIDTH +: WIDTH];
  end

  assign w_sample  = w_ch[r_sel_cur];
  assign w_req_oor = ({1'b0, sel_req} >= c_N_CH);

`ifdef CHAN_MUX_HOLD_EN
  assign w_blank_data = r_data_out;
`else
  assign w_blank_data = '0;
`endif

  // Next-state and output decode; sel_cur is committed one edge before the
  // FSM leaves BLANK so that the exit edge already samples the new channel.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_sel_nxt   = r_sel_cur;
    w_data_nxt  = w_sample;
    w_valid_nxt = 1'b1;
    w_err_nxt   = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_ready = 1'b1;
        if (sel_valid) begin
          if (w_req_oor) begin
            w_err_nxt = 1'b1;
          end else if (sel_req != r_sel_cur) begin
            w_pend_nxt  = sel_req;
            w_cnt_nxt   = c_CNT_LOAD;
            w_state_nxt = ST_BLANK;
            w_valid_nxt = 1'b0;
            w_data_nxt  = w_blank_data;
            // A one-cycle window has no later edge to commit on
            if (BLANK_CYC == 1) begin
              w_sel_nxt = sel_req;
            end
          end
        end
      end
      ST_BLANK: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt   = r_cnt - c_CNT_ONE;
          w_valid_nxt = 1'b0;
          w_data_nxt  = w_blank_data;
          if (r_cnt == c_CNT_ONE) begin
            w_sel_nxt = r_pend;
          end
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // State and output registers; reset aborts any switch in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_cnt      <= '0;
      r_pend     <= '0;
      r_sel_cur  <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pend     <= w_pend_nxt;
      r_sel_cur  <= w_sel_nxt;
      r_data_out <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign sel_ready      = w_ready;
  assign sel_cur        = r_sel_cur;
  assign data_out       = r_data_out;
  assign data_out_valid = r_valid;
  assign sel_err        = r_err;

endmodule
`default_nettype wire
